// File: rtl/sd_pad_pkg.sv
// Shared definitions for the SD DAT pad bank: direction states, bus-width
// encodings and the lane-mask helper.
package sd_pad_pkg;

    localparam int MAX_LANES = 8;
    localparam int CNT_W     = 8;

    localparam logic [1:0] BW_1 = 2'b00;
    localparam logic [1:0] BW_4 = 2'b01;
    localparam logic [1:0] BW_8 = 2'b10;

    typedef enum logic [2:0] {
        LISTEN   = 3'd0,
        TURN_OUT = 3'd1,
        DRIVE    = 3'd2,
        PARK_HI  = 3'd3,
        TURN_IN  = 3'd4
    } state_t;

    // Lanes enabled for a bus-width code; the reserved code 11 falls back to
    // 1-bit, and lanes that do not physically exist are always cleared.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] bw, input int lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        case (bw)
            BW_4:    m[3:0] = '1;
            BW_8:    m = '1;
            default: m[0] = 1'b1;
        endcase
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i >= lanes) m[i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/sd_pad_sync.sv
// Input register chain for the DAT pins. Resets to all ones so a freshly
// reset bus reads as idle (pulled up).
module sd_pad_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    // Shift the pin samples through STAGES registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '1;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/sd_dat_pad_bank.sv
// Multi-lane SD DAT pad controller: registered pin outputs, registered and
// masked pin inputs, and a direction FSM that parks the lanes high and then
// releases them for a turnaround gap before either side may drive.
//
// Handshake: dir_req is a level request (1 = host wants the bus). It is
// registered once before the FSM acts on it; dir_ack is a registered level
// that is high exactly while the bus is in DRIVE, so o_port carries host data
// on every cycle dir_ack is high. Dropping dir_req is the only way to release.
module sd_dat_pad_bank
    import sd_pad_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int TURN      = 2,
    parameter int PARK      = 1,
    parameter int IN_STAGES = 1
) (
    input  logic             sd_clock,
    input  logic             reset,
    input  logic [1:0]       bus_width,
    input  logic             dir_req,
    input  logic [LANES-1:0] data_in,
    output logic [LANES-1:0] data_out,
    output logic             in_valid,
    output logic             dir_ack,
    input  logic [LANES-1:0] i_port,
    output logic [LANES-1:0] o_port,
    output logic [LANES-1:0] oe,
    output state_t           dbg_state
);

    localparam logic [1:0]       SETTLE    = 2'(IN_STAGES);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN - 1);
    localparam logic [CNT_W-1:0] PARK_LOAD = CNT_W'(PARK - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             width_q;
    logic                   req_q;
    logic [1:0]             listen_cnt;
    logic [MAX_LANES-1:0]   mask_full;
    logic [LANES-1:0]       act;
    logic [LANES-1:0]       pins_q;

    // Width is only sampled in LISTEN, so the mask is frozen for a whole
    // drive session and input gating stays stable while the bus is owned.
    assign mask_full = lane_mask(width_q, LANES);
    assign act       = mask_full[LANES-1:0];

    sd_pad_sync #(
        .WIDTH  (LANES),
        .STAGES (IN_STAGES)
    ) u_sync (
        .clk (sd_clock),
        .rst (reset),
        .d   (i_port),
        .q   (pins_q)
    );

    // Inactive lanes read as pulled-up ones.
    assign data_out  = pins_q | ~act;
    assign in_valid  = (state == LISTEN) && (listen_cnt == SETTLE);
    assign dbg_state = state;

    // Direction FSM with counter and registered pad outputs.
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state      <= LISTEN;
            cnt        <= '0;
            width_q    <= BW_1;
            req_q      <= 1'b0;
            listen_cnt <= '0;
            oe         <= '0;
            o_port     <= '1;
            dir_ack    <= 1'b0;
        end else begin
            req_q <= dir_req;
            case (state)
                LISTEN: begin
                    width_q <= bus_width;
                    if (listen_cnt != SETTLE) listen_cnt <= listen_cnt + 2'd1;
                    if (req_q) begin
                        state      <= TURN_OUT;
                        cnt        <= TURN_LOAD;
                        listen_cnt <= '0;
                    end
                end
                TURN_OUT: begin
                    if (!req_q) begin
                        state <= LISTEN;
                    end else if (cnt == '0) begin
                        state   <= DRIVE;
                        oe      <= act;
                        o_port  <= data_in & act;
                        dir_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (!req_q) begin
                        state   <= PARK_HI;
                        cnt     <= PARK_LOAD;
                        o_port  <= '1;
                        dir_ack <= 1'b0;
                    end else begin
                        o_port <= data_in & act;
                    end
                end
                PARK_HI: begin
                    if (cnt == '0) begin
                        state <= TURN_IN;
                        cnt   <= TURN_LOAD;
                        oe    <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                TURN_IN: begin
                    if (cnt == '0) begin
                        state <= LISTEN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= LISTEN;
                    oe      <= '0;
                    o_port  <= '1;
                    dir_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_pad_bank.sv
// Bench for sd_dat_pad_bank: sessions of listen/request/release with random
// data, pin values and widths; expected pad behaviour is derived from the
// session timeline (request edge, hold length) and checked cycle by cycle.
module tb_sd_dat_pad_bank;
    import sd_pad_pkg::*;

    localparam int LANES     = 8;
    localparam int TURN      = 2;
    localparam int PARK      = 1;
    localparam int IN_STAGES = 2;
    localparam int HMAX      = 8192;

    // ---------------- clock / reset / DUT ----------------
    logic       sd_clock = 1'b0;
    logic       reset;
    logic [1:0] bus_width;
    logic       dir_req;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       in_valid;
    logic       dir_ack;
    logic [7:0] i_port;
    logic [7:0] o_port;
    logic [7:0] oe;
    state_t     dbg_state;

    always #5 sd_clock = ~sd_clock;

    sd_dat_pad_bank #(
        .LANES     (LANES),
        .TURN      (TURN),
        .PARK      (PARK),
        .IN_STAGES (IN_STAGES)
    ) dut (
        .sd_clock  (sd_clock),
        .reset     (reset),
        .bus_width (bus_width),
        .dir_req   (dir_req),
        .data_in   (data_in),
        .data_out  (data_out),
        .in_valid  (in_valid),
        .dir_ack   (dir_ack),
        .i_port    (i_port),
        .o_port    (o_port),
        .oe        (oe),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int listen_e = 0;
    bit pre_raised = 1'b0;
    bit mon_en = 1'b0;

    logic [7:0]  ihist  [HMAX];
    logic [1:0]  bwhist [HMAX];
    logic [17:0] exp_q      [$];
    logic [7:0]  exp_dout_q [$];

    function automatic logic [7:0] mask_of(input logic [1:0] bw);
        case (bw)
            2'b01:   return 8'h0F;
            2'b10:   return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic req, input logic [1:0] bw, input logic [7:0] din);
        dir_req   = req;
        bus_width = bw;
        data_in   = din;
        i_port    = 8'($urandom);
        @(posedge sd_clock);
        cyc++;
        ihist[cyc]  = i_port;
        bwhist[cyc] = bw;
        #1;
    endtask

    // One session starting in LISTEN: wait gap edges, hold dir_req for r
    // edges, then release. Abort when r <= TURN. Optionally change width
    // mid-drive and raise the next request early (during the release).
    task automatic run_session(input logic [1:0] bw, input int gap, input int r, input int fixd,
                               input bit mid_chg, input logic [1:0] bw2, input int early);
        int n, d0, m, e_end, c0;
        bit abort, req, lst, drv, prk, iv;
        logic [7:0] msk, din, e_oe, e_op;
        logic [1:0] bwc;
        c0    = cyc;
        n     = pre_raised ? cyc : cyc + gap;
        abort = (r <= TURN);
        d0    = n + 1 + TURN;
        m     = n + r;
        e_end = abort ? n + 1 + r : m + 1 + PARK + TURN;
        msk   = mask_of(bw);
        for (int c = c0 + 1; c <= e_end; c++) begin
            req = (c >= n && c < n + r) || (!abort && early > 0 && c >= e_end - early);
            bwc = (mid_chg && !abort && c > d0) ? bw2 : bw;
            din = (fixd >= 0) ? 8'(fixd) : 8'($urandom);
            step(req, bwc, din);
            lst  = (c <= n) || (c >= e_end);
            iv   = lst && ((c <= n) ? (c - listen_e >= IN_STAGES) : (c - e_end >= IN_STAGES));
            drv  = !abort && c >= d0 && c <= m;
            prk  = !abort && c > m && c <= m + PARK;
            e_oe = (drv || prk) ? msk : 8'h00;
            e_op = drv ? (din & msk) : 8'hFF;
            exp_q.push_back({drv, iv, e_oe, e_op});
            if (iv) exp_dout_q.push_back(ihist[c - (IN_STAGES - 1)] | ~mask_of(bwc));
            mon_en = 1'b1;
        end
        listen_e   = e_end;
        pre_raised = !abort && early > 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [17:0] pe;
    logic [7:0]  de;
    always @(negedge sd_clock) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pad_trace: DUT output with no expectation queued (edge %0d)", cyc);
            end else begin
                pe = exp_q.pop_front();
                check("pad_trace{ack,valid,oe,o_port}", {14'd0, dir_ack, in_valid, oe, o_port}, {14'd0, pe});
            end
            if (in_valid) begin
                if (exp_dout_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL data_out: in_valid high with no expectation queued (edge %0d)", cyc);
                end else begin
                    de = exp_dout_q.pop_front();
                    check("data_out", data_out, de);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; dir_req = 1'b0; bus_width = 2'b00; data_in = 8'h00; i_port = 8'hFF;
        repeat (2) @(posedge sd_clock);
        #1;
        check("reset_oe", oe, 8'h00);
        check("reset_o_port", o_port, 8'hFF);
        check("reset_data_out", data_out, 8'hFF);
        check("reset_dir_ack", dir_ack, 1'b0);
        check("reset_in_valid", in_valid, 1'b0);
        @(negedge sd_clock);
        reset = 1'b0;
        cyc = 0;
        listen_e = 0;

        // directed sessions
        run_session(2'b10, 3, 6, 8'hA5, 1'b0, 2'b00, 0);     // 8-bit drive of A5
        run_session(2'b00, 4, 4, 8'hFF, 1'b0, 2'b00, 0);     // 1-bit: oe=01, o_port=01
        run_session(2'b01, 3, 1, -1, 1'b0, 2'b00, 0);        // abort after one cycle
        run_session(2'b01, 2, TURN, -1, 1'b0, 2'b00, 0);     // abort on the last turn cycle
        run_session(2'b10, 2, TURN + 1, -1, 1'b0, 2'b00, 0); // shortest real drive
        run_session(2'b01, 3, 7, -1, 1'b1, 2'b10, 0);        // 4->8 change mid-drive
        run_session(2'b10, 3, 4, -1, 1'b0, 2'b00, PARK + TURN); // next request raised during release
        run_session(2'b11, 0, 5, -1, 1'b0, 2'b00, 1);        // reserved width, starts on LISTEN entry
        run_session(2'b10, 0, 1, -1, 1'b0, 2'b00, 0);        // abort right on LISTEN entry

        // random sessions
        for (int s = 0; s < 40; s++) begin
            run_session(2'($urandom_range(0, 3)), $urandom_range(1, 5), $urandom_range(1, 8), -1,
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, PARK + TURN));
        end
        run_session(2'b10, 2, 1, -1, 1'b0, 2'b00, 0);        // leave the bus idle in LISTEN

        @(negedge sd_clock);
        #1;
        mon_en = 1'b0;
        check("pad_queue_drained", exp_q.size(), 0);
        check("dout_queue_drained", exp_dout_q.size(), 0);

        // reset in the middle of an 8-bit drive
        for (int k = 0; k < 2 + TURN; k++) step(1'b1, 2'b10, 8'h5A);
        check("drive_oe", oe, 8'hFF);
        check("drive_dir_ack", dir_ack, 1'b1);
        check("drive_o_port", o_port, 8'h5A);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_oe", oe, 8'h00);
        check("async_reset_o_port", o_port, 8'hFF);
        check("async_reset_data_out", data_out, 8'hFF);
        check("async_reset_dir_ack", dir_ack, 1'b0);
        check("async_reset_in_valid", in_valid, 1'b0);
        check("async_reset_state", dbg_state, LISTEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog: run did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_dat_pad_bank.md
# sd_dat_pad_bank

Parametrised multi-lane pad controller for the SD host DAT bus, the successor to the single-line CMD `pad`. It sits between the DAT serialiser/deserialiser and the physical bidirectional pins. It provides registered output and input paths and lane masking for 1/4/8-bit bus modes. A direction state machine inserts turnaround and park cycles, so host and card never drive the lines at the same time.

## Interface
- `LANES`, 8, number of physical DAT lanes (1, 4 or 8).
- `TURN`, 2, turnaround cycles with all lanes released (≥1).
- `PARK`, 1, cycles lanes are driven high before release (≥1).
- `IN_STAGES`, 1, input register stages on `i_port` (1 or 2).
- `sd_clock` input 1: sole clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `bus_width` input 2: 00 = 1-bit, 01 = 4-bit, 10 = 8-bit; 11 is treated as 00.
- `dir_req` input 1: 1 = host requests to drive, 0 = listen.
- `data_in` input LANES: data from host logic to pins.
- `data_out` output LANES: sampled pin data to host logic.
- `in_valid` output 1: `data_out` reflects settled card data.
- `dir_ack` output 1: high only while in DRIVE.
- `i_port` input LANES: pin input buffers.
- `o_port` output LANES: pin output values.
- `oe` output LANES: per-lane output enable, 1 = drive.

## Operation
- States: LISTEN, TURN_OUT, DRIVE, PARK_HI, TURN_IN. Reset state is LISTEN.
- Active lane mask: 1-bit mode = lane 0; 4-bit mode = lanes 0–3; 8-bit mode = all lanes. Lanes at or above `LANES` are ignored.
- Width latching: `bus_width` is latched only while in LISTEN. Changes in any other state take effect on the next return to LISTEN.
- LISTEN: `oe` = 0. If `dir_req` = 1, go to TURN_OUT and load the counter with TURN−1.
- TURN_OUT: `oe` = 0 and the counter decrements.
  - If `dir_req` drops, abort to LISTEN. `oe` is never asserted in this case.
  - When the counter reaches 0, go to DRIVE.
- DRIVE: `oe` = active mask, `o_port` = registered `data_in`, and inactive lanes drive 0 with `oe` = 0. If `dir_req` = 0, go to PARK_HI with counter PARK−1.
- PARK_HI: `oe` = active mask and `o_port` = all ones. When the counter reaches 0, go to TURN_IN with counter TURN−1.
- TURN_IN: `oe` = 0. When the counter reaches 0, go to LISTEN.
- `dir_req` during PARK_HI or TURN_IN is ignored until LISTEN is reached; a new TURN_OUT starts from there.
- Input path: `data_out` = `i_port` delayed by IN_STAGES registers, gated by the mask. Inactive lanes read 1, as with the pull-up.
- `in_valid`: 1 once IN_STAGES consecutive cycles have elapsed in LISTEN. It drops to 0 in the same cycle LISTEN is left.

## Timing
- Reset values: `oe` = 0, `o_port` = all ones, `data_out` = all ones, `in_valid` = 0, `dir_ack` = 0, latched width = 1-bit, counter = 0.
- Output latency: `data_in` → `o_port` is 1 cycle (registered).
- Input latency: `i_port` → `data_out` is IN_STAGES cycles.
- Drive handshake:
  - `dir_req` sampled high in LISTEN at edge N gives `oe` high from edge N+1+TURN.
  - `dir_ack` rises on that same edge.
  - The first valid `o_port` is the `data_in` sampled at that edge.
- Release:
  - `dir_req` sampled low in DRIVE at edge M gives `dir_ack` = 0 and `o_port` = 1s from M+1.
  - `oe` = 0 from M+1+PARK.
  - LISTEN is reached at M+1+PARK+TURN.
- `oe`, `o_port` and `dir_ack` are all register outputs (glitch-free).
- Reset mid-DRIVE: `oe` clears asynchronously and immediately; no park phase.

## Structure
- Shared package `sd_pad_pkg`:
  - state enum;
  - bus-width encodings `BW_1`, `BW_4`, `BW_8`;
  - a function mapping `bus_width` and LANES to the lane mask.
- Sub-module `sd_pad_sync`: a parametrised IN_STAGES-deep input register with reset-to-ones. One instance spans all lanes.
- The FSM, counter, and output registers live in the top module.

## Test plan
- Reset: assert `reset` mid-DRIVE with `oe` = 8'hFF → `oe` = 0, `o_port` = 8'hFF, `data_out` = 8'hFF, `dir_ack` = 0 without waiting for a clock edge.
- Drive cycle with 8-bit mode, TURN = 2, PARK = 1:
  - `dir_req` ↑ at edge 0 → `oe` = FF and `dir_ack` = 1 at edge 3;
  - `data_in` = A5 appears on `o_port` one cycle later;
  - `dir_req` ↓ → `o_port` = FF for 1 cycle, then `oe` = 0, then LISTEN 2 cycles later.
- 1-bit mode: `data_in` = FF → `oe` = 01, `o_port` = 01. Drive `i_port` = 00 in LISTEN → `data_out` = FE.
- Abort: `dir_req` high 1 cycle only, dropping in TURN_OUT → `oe` stays 0 throughout and LISTEN returns with no PARK_HI.
- Width change while driving: switch `bus_width` 4→8 in DRIVE → mask stays 0F until the next LISTEN, then FF on the next drive.
- Input latency with IN_STAGES = 2: `i_port` toggles 00→3C in LISTEN → `data_out` = 3C two cycles later; `in_valid` rises 2 cycles after LISTEN entry.
